// File: rtl/tt_sweep_ctrl.sv
// Truth-table sweep sequencer for a 3-input gate: drives all eight input vectors,
// samples the gate after a settle time and reports the 8-bit word. Optional check: TT_SWEEP_CHECK_EN.
module tt_sweep_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter logic [7:0]  EXPECTED      = 8'h9C
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   output logic       in1,
   output logic       in2,
   output logic       in3,
   input  logic       gate_out,
   output logic       busy,
   output logic       done,
   output logic [7:0] tt,
   output logic       mismatch
);

   localparam int unsigned    CW     = $clog2(SETTLE_CYCLES + 1);
   localparam logic [CW-1:0]  RELOAD = CW'(SETTLE_CYCLES - 1);

   if (SETTLE_CYCLES < 1 || $bits(EXPECTED) != 8) begin : g_bad_param
      $error("tt_sweep_ctrl: SETTLE_CYCLES must be >= 1");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_DONE
   } state_e;

   state_e          state_q, state_d;
   logic [2:0]      idx_q, idx_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [7:0]      cap_q, cap_d;
   logic [7:0]      tt_q, tt_d;
   logic [2:0]      vec_q, vec_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      cap_d   = cap_q;
      tt_d    = tt_q;
      case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               state_d = S_SETTLE;
               idx_d   = '0;
               cnt_d   = RELOAD;
            end
         end
         S_SETTLE: begin
            if (abort) begin
               state_d = S_IDLE;
               idx_d   = '0;
               cnt_d   = '0;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - CW'(1);
            end else begin
               // The final sample is folded straight into tt so it is valid during done.
               cap_d = {cap_q[6:0], gate_out};
               if (idx_q != 3'd7) begin
                  idx_d = idx_q + 3'd1;
                  cnt_d = RELOAD;
               end else begin
                  state_d = S_DONE;
                  tt_d    = cap_d;
               end
            end
         end
         S_DONE: begin
            idx_d = '0;
            cnt_d = '0;
            if (start && !abort) begin
               state_d = S_SETTLE;
               cnt_d   = RELOAD;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
         end
      endcase
      busy_d = (state_d == S_SETTLE);
      done_d = (state_d == S_DONE);
      vec_d  = (state_d == S_SETTLE) ? idx_d : 3'b000;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         cap_q   <= '0;
         tt_q    <= '0;
         vec_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         cap_q   <= cap_d;
         tt_q    <= tt_d;
         vec_q   <= vec_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

`ifdef TT_SWEEP_CHECK_EN
   logic mismatch_q, mismatch_d;

   always_comb begin
      mismatch_d = mismatch_q;
      if (state_q == S_SETTLE && state_d == S_DONE) begin
         mismatch_d = (tt_d != EXPECTED);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mismatch_q <= 1'b0;
      end else begin
         mismatch_q <= mismatch_d;
      end
   end

   assign mismatch = mismatch_q;
`else
   assign mismatch = 1'b0;
`endif

   assign {in1, in2, in3} = vec_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign tt              = tt_q;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Directed bench for tt_sweep_ctrl: S=4 instance for most scenarios, S=1 instance for minimum settle.
module tb_tt_sweep_ctrl;

   logic       clk;
   logic       rst_n;
   logic       start, abort;
   logic       in1, in2, in3;
   logic       gate_out;
   logic       busy, done, mismatch;
   logic [7:0] tt;
   logic       inv;

   logic       start_m, abort_m;
   logic       in1_m, in2_m, in3_m;
   logic       gate_out_m;
   logic       busy_m, done_m, mismatch_m;
   logic [7:0] tt_m;

   logic [7:0] func;
   int         n_cmp;
   int         n_err;

   tt_sweep_ctrl #(.SETTLE_CYCLES(4), .EXPECTED(8'h9C)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .in1(in1), .in2(in2), .in3(in3), .gate_out(gate_out),
      .busy(busy), .done(done), .tt(tt), .mismatch(mismatch)
   );

   tt_sweep_ctrl #(.SETTLE_CYCLES(1), .EXPECTED(8'h9C)) dut_min (
      .clk(clk), .rst_n(rst_n), .start(start_m), .abort(abort_m),
      .in1(in1_m), .in2(in2_m), .in3(in3_m), .gate_out(gate_out_m),
      .busy(busy_m), .done(done_m), .tt(tt_m), .mismatch(mismatch_m)
   );

   // Behavioural 0x9C gate: output for vector v is bit [7-v] of the word.
   always_comb begin
      logic [2:0] v;
      logic [2:0] vm;
      v          = {in1, in2, in3};
      vm         = {in1_m, in2_m, in3_m};
      gate_out   = func[~v] ^ inv;
      gate_out_m = func[~vm];
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      @(negedge clk);
      n_cmp++;
      if ({busy, done, in1, in2, in3} !== 5'b00000) begin
         n_err++;
         $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, in1, in2, in3});
      end
      n_cmp++;
      if (tt !== 8'h00 || mismatch !== 1'b0) begin
         n_err++;
         $display("FAIL reset_tt: got tt=%h mm=%b expected tt=00 mm=0", tt, mismatch);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Basic sweep with per-cycle vector checks; inv selects the inverted function.
   task automatic test_sweep(input logic invert, input logic [7:0] exp_tt, input logic exp_mm);
      logic [4:0] exp_ctrl;
      inv   = invert;
      start = 1'b1;
      for (int c = 1; c <= 34; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (c <= 32) exp_ctrl = {2'b10, 3'((c - 1) / 4)};
         else if (c == 33) exp_ctrl = 5'b01000;
         else exp_ctrl = 5'b00000;
         n_cmp++;
         if ({busy, done, in1, in2, in3} !== exp_ctrl) begin
            n_err++;
            $display("FAIL sweep_ctrl c=%0d: got %b expected %b", c, {busy, done, in1, in2, in3}, exp_ctrl);
         end
         if (c == 33) begin
            n_cmp++;
            if (tt !== exp_tt || mismatch !== exp_mm) begin
               n_err++;
               $display("FAIL sweep_result: got tt=%h mm=%b expected tt=%h mm=%b", tt, mismatch, exp_tt, exp_mm);
            end
         end
      end
      inv = 1'b0;
   endtask

   task automatic test_abort();
      start = 1'b1;
      for (int c = 1; c <= 15; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (c == 14) begin
            n_cmp++;
            if ({busy, in1, in2, in3} !== 4'b1011) begin
               n_err++;
               $display("FAIL abort_pre: got %b expected 1011", {busy, in1, in2, in3});
            end
            abort = 1'b1;
         end
      end
      abort = 1'b0;
      n_cmp++;
      if ({busy, done, in1, in2, in3} !== 5'b00000 || tt !== 8'h9C) begin
         n_err++;
         $display("FAIL abort_post: got ctrl=%b tt=%h expected ctrl=00000 tt=9c", {busy, done, in1, in2, in3}, tt);
      end
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         n_cmp++;
         if ({busy, done} !== 2'b00) begin
            n_err++;
            $display("FAIL abort_quiet c=%0d: got %b expected 00", c, {busy, done});
         end
      end
      n_cmp++;
      if (tt !== 8'h9C) begin
         n_err++;
         $display("FAIL abort_tt: got %h expected 9c", tt);
      end
   endtask

   task automatic test_start_mid();
      logic [4:0] exp_ctrl;
      start = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         start = (c == 5 || c == 20);
         if (c <= 32) exp_ctrl = {2'b10, 3'((c - 1) / 4)};
         else if (c == 33) exp_ctrl = 5'b01000;
         else exp_ctrl = 5'b00000;
         n_cmp++;
         if ({busy, done, in1, in2, in3} !== exp_ctrl) begin
            n_err++;
            $display("FAIL start_mid c=%0d: got %b expected %b", c, {busy, done, in1, in2, in3}, exp_ctrl);
         end
      end
      start = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [4:0] exp_ctrl;
      int         cc;
      start = 1'b1;
      for (int c = 1; c <= 67; c++) begin
         @(negedge clk);
         if (c == 34) start = 1'b0;
         cc = (c <= 33) ? c : c - 33;
         if (c == 67) exp_ctrl = 5'b00000;
         else if (cc == 33) exp_ctrl = 5'b01000;
         else exp_ctrl = {2'b10, 3'((cc - 1) / 4)};
         n_cmp++;
         if ({busy, done, in1, in2, in3} !== exp_ctrl) begin
            n_err++;
            $display("FAIL b2b c=%0d: got %b expected %b", c, {busy, done, in1, in2, in3}, exp_ctrl);
         end
         if (c == 66) begin
            n_cmp++;
            if (tt !== 8'h9C) begin
               n_err++;
               $display("FAIL b2b_tt: got %h expected 9c", tt);
            end
         end
      end
   endtask

   task automatic test_async_reset();
      start = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({busy, done, in1, in2, in3} !== 5'b00000 || tt !== 8'h00 || mismatch !== 1'b0) begin
         n_err++;
         $display("FAIL async_rst: got ctrl=%b tt=%h mm=%b expected ctrl=00000 tt=00 mm=0",
                  {busy, done, in1, in2, in3}, tt, mismatch);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         n_cmp++;
         if ({busy, done, in1, in2, in3} !== 5'b00000 || tt !== 8'h00) begin
            n_err++;
            $display("FAIL async_rst_quiet c=%0d: got ctrl=%b tt=%h expected ctrl=00000 tt=00",
                     c, {busy, done, in1, in2, in3}, tt);
         end
      end
   endtask

   task automatic test_min_settle();
      logic [4:0] exp_ctrl;
      start_m = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         start_m = 1'b0;
         if (c <= 8) exp_ctrl = {2'b10, 3'(c - 1)};
         else if (c == 9) exp_ctrl = 5'b01000;
         else exp_ctrl = 5'b00000;
         n_cmp++;
         if ({busy_m, done_m, in1_m, in2_m, in3_m} !== exp_ctrl) begin
            n_err++;
            $display("FAIL min_settle c=%0d: got %b expected %b", c, {busy_m, done_m, in1_m, in2_m, in3_m}, exp_ctrl);
         end
         if (c == 9) begin
            n_cmp++;
            if (tt_m !== 8'h9C || mismatch_m !== 1'b0) begin
               n_err++;
               $display("FAIL min_settle_tt: got tt=%h mm=%b expected tt=9c mm=0", tt_m, mismatch_m);
            end
         end
      end
   endtask

   initial begin
      logic wrong_mm;
`ifdef TT_SWEEP_CHECK_EN
      wrong_mm = 1'b1;
`else
      wrong_mm = 1'b0;
`endif
      n_cmp   = 0;
      n_err   = 0;
      func    = 8'h9C;
      inv     = 1'b0;
      rst_n   = 1'b0;
      start   = 1'b0;
      abort   = 1'b0;
      start_m = 1'b0;
      abort_m = 1'b0;

      test_reset();
      test_sweep(1'b0, 8'h9C, 1'b0);
      test_sweep(1'b1, 8'h63, wrong_mm);
      test_sweep(1'b0, 8'h9C, 1'b0);
      test_abort();
      test_start_mid();
      test_back_to_back();
      test_async_reset();
      test_min_settle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/tt_sweep_ctrl.md
# tt_sweep_ctrl

Sequencer that characterises a 3-input combinational logic gate (e.g. the 0x9C function block) by sweeping all eight input vectors {in1,in2,in3} = 000…111. Each vector is held for a programmable settle time, after which the gate output is sampled. The resulting 8-bit truth-table word is reported with a one-cycle done pulse. It sits between the bench/host control logic and the gate under test, and owns the gate's input pins for the duration of a sweep.

## Interface
Parameters:
- SETTLE_CYCLES, default 4: cycles each vector is held before sampling; legal range >= 1.
- EXPECTED, default 8'h9C: reference truth-table word. Used only when the check feature is compiled in.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a sweep; sampled on the rising edge.
- abort  input  1  cancel a sweep in progress.
- in1, in2, in3  output  1 each  vector driven to the gate under test.
- gate_out  input  1  output of the gate under test.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when a sweep completes.
- tt  output  8  last completed truth table; bit [7-idx] holds the gate output for idx = {in1,in2,in3}.
- mismatch  output  1  tt != EXPECTED; valid from done onward.

## Operation
- States:
  - IDLE: busy=0, inputs=000.
  - SETTLE: busy=1.
  - DONE: done=1, busy=0, one cycle.
- IDLE to SETTLE: start=1 and abort=0. Vector index idx=0 and settle counter=SETTLE_CYCLES-1 are loaded.
- In SETTLE, {in1,in2,in3}=idx.
  - Counter > 0: decrement.
  - Counter == 0: shift gate_out into the internal capture register (MSB-first, idx 0 lands in tt[7]).
  - Then, if idx<7: idx++ and reload the counter. If idx==7: go to DONE.
- Entering DONE: the 8-bit capture word (including the final sample) is written to tt, and mismatch is updated.
- From DONE:
  - start=1 and abort=0: go to SETTLE with idx=0 (back-to-back sweep).
  - Otherwise: go to IDLE.
- start while in SETTLE is ignored.
- abort=1 in SETTLE: next state is IDLE. Inputs return to 000, and tt, mismatch and done are unaffected.
- abort=1 in IDLE or DONE: suppresses start.
- Counter width is $clog2(SETTLE_CYCLES+1). idx is 3 bits and never wraps within a sweep.
- Reset values: state=IDLE, in1=in2=in3=0, busy=0, done=0, tt=8'h00, mismatch=0, idx=0, counter=0, capture register=0.
- Reset asserted mid-sweep: immediate return to the reset values with no done pulse. tt is cleared.

## Timing
- Let edge 0 be the edge that samples start. Cycles 1…8·SETTLE_CYCLES are SETTLE cycles.
- Vector k is driven during cycles k·S+1 … (k+1)·S, where S = SETTLE_CYCLES.
- gate_out is sampled at the edge ending cycle (k+1)·S.
- done=1 during cycle 8·S+1. tt and mismatch are valid in that same cycle and hold until the next completed sweep or reset.
- Sweep latency: start edge to done-high is 8·S+1 cycles.
- Minimum period for back-to-back sweeps: 8·S+1 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- TT_SWEEP_CHECK_EN defined: mismatch is registered and updated on entry to DONE as (capture word != EXPECTED). Its reset value is 0.
- TT_SWEEP_CHECK_EN undefined: mismatch is tied to 0, EXPECTED is unused, and no comparator is synthesised. All other behaviour is identical.

## Test plan
- Basic sweep:
  - Stimulus: behavioural 0x9C gate, S=4, start pulse at edge 0.
  - Required: the vector sequence 000…111, each held 4 cycles. done in cycle 33, tt=8'h9C, mismatch=0.
- Wrong function (macro defined):
  - Stimulus: gate model returns the inverted function.
  - Required: tt=8'h63, mismatch=1.
  - With the macro undefined: mismatch stays 0.
- Abort:
  - Stimulus: after a good sweep (tt=8'h9C), start a second sweep and assert abort during vector 3.
  - Required: next cycle busy=0 and inputs=000, no done pulse, tt stays 8'h9C.
- Start handling:
  - Stimulus: start pulses mid-sweep.
  - Required: ignored; exactly one done pulse, at cycle 33.
  - Stimulus: start held high through the done cycle.
  - Required: a second sweep begins in cycle 34 with idx=0.
- Asynchronous reset:
  - Stimulus: rst_n pulled low between clock edges mid-sweep.
  - Required: immediate busy=0, inputs=000, tt=8'h00, no done pulse after release.
- Minimum settle:
  - Stimulus: S=1 with the 0x9C model.
  - Required: each vector held 1 cycle, done in cycle 9, tt=8'h9C.
